// File: rtl/i2c_pkg.sv
// i2c_pkg: types and constants shared by the I2C master and slaves.
// State encoding, slot/phase counts, R/W bit values.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    START,
    ADDR,
    ADDR_ACK,
    WRITE,
    WRITE_ACK,
    READ,
    READ_NACK,
    STOP
  } state_t;

  localparam int PHASES_PER_SLOT = 4;
  localparam int BITS_PER_BYTE   = 8;

  localparam logic I2C_WRITE = 1'b0;
  localparam logic I2C_READ  = 1'b1;

endpackage

// File: rtl/i2c_phase_gen.sv
// i2c_phase_gen: CLK_DIV prescaler and 2-bit phase counter.
// Ports: clk, rst, en in; phase, phase_end, slot_end out.
module i2c_phase_gen
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 250
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic [1:0] phase,
  output logic       phase_end,
  output logic       slot_end
);

  logic [9:0] cnt;

  assign phase_end = en && (cnt == 10'(CLK_DIV - 1));
  assign slot_end  = phase_end &&
                     (phase == 2'(PHASES_PER_SLOT - 1));

  // Held at zero while idle so a new transaction
  // always starts at phase 0, count 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      phase <= '0;
    end else if (!en) begin
      cnt   <= '0;
      phase <= '0;
    end else if (phase_end) begin
      cnt   <= '0;
      phase <= phase + 2'd1;
    end else begin
      cnt <= cnt + 10'd1;
    end
  end

endmodule

// File: rtl/i2c_master.sv
// i2c_master: single-byte I2C master (START, addr+R/W, 1 byte, STOP).
// Ports: clk, rst, start, rw, addr, wdata in; rdata, busy, done,
// ack_err, scl out; sda inout (open drain).
// Macro I2C_ACK_ABORT_EN: a NACK jumps straight to STOP.
module i2c_master
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 250
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       scl,
  inout  wire        sda
);

  state_t     state, state_nx;
  logic [1:0] phase;
  logic       phase_end, slot_end;
  logic [6:0] addr_q;
  logic       rw_q;
  logic [7:0] wdata_q;
  logic [2:0] bit_cnt;
  logic       sda_oe;
  logic       sda_in;
  logic       abort;
  logic       last_bit;
  logic [7:0] tx_byte;
  logic       tx_bit;
  logic       is_ack;

  assign sda    = sda_oe ? 1'b0 : 1'bz;
  assign sda_in = sda;

  assign last_bit = bit_cnt == 3'(BITS_PER_BYTE - 1);
  assign tx_byte  = (state == ADDR) ? {addr_q, rw_q} : wdata_q;
  assign tx_bit   = tx_byte[3'd7 - bit_cnt];
  assign is_ack   = (state == ADDR_ACK) || (state == WRITE_ACK);

`ifdef I2C_ACK_ABORT_EN
  assign abort = ack_err;
`else
  assign abort = 1'b0;
`endif

  i2c_phase_gen #(.CLK_DIV(CLK_DIV)) u_phase (
    .clk       (clk),
    .rst       (rst),
    .en        (state != IDLE),
    .phase     (phase),
    .phase_end (phase_end),
    .slot_end  (slot_end)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    scl      = phase[1];
    unique case (state)
      IDLE: begin
        scl = 1'b1;
        if (start) state_nx = START;
      end
      START: begin
        scl = 1'b1;
        if (slot_end) state_nx = ADDR;
      end
      ADDR:
        if (slot_end && last_bit) state_nx = ADDR_ACK;
      ADDR_ACK:
        if (slot_end) begin
          if (abort)                state_nx = STOP;
          else if (rw_q == I2C_READ) state_nx = READ;
          else                      state_nx = WRITE;
        end
      WRITE:
        if (slot_end && last_bit) state_nx = WRITE_ACK;
      WRITE_ACK:
        if (slot_end) state_nx = STOP;
      READ:
        if (slot_end && last_bit) state_nx = READ_NACK;
      READ_NACK:
        if (slot_end) state_nx = STOP;
      STOP:
        if (slot_end) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // SDA moves one phase after SCL falls; it is sampled
  // on the last clock of phase 2 (SCL high).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      rw_q    <= 1'b0;
      wdata_q <= '0;
      rdata   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      ack_err <= 1'b0;
      bit_cnt <= '0;
      sda_oe  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE && start) begin
        addr_q  <= addr;
        rw_q    <= rw;
        wdata_q <= wdata;
        ack_err <= 1'b0;
        busy    <= 1'b1;
        bit_cnt <= '0;
      end
      if (state == STOP && slot_end) begin
        done <= 1'b1;
        busy <= 1'b0;
      end
      if (slot_end &&
          (state == ADDR || state == WRITE || state == READ))
        bit_cnt <= bit_cnt + 3'd1;
      if (phase_end) begin
        unique case (phase)
          2'd0:
            if (state == ADDR || state == WRITE)
              sda_oe <= ~tx_bit;
            else if (state == STOP)
              sda_oe <= 1'b1;
            else if (state != START)
              sda_oe <= 1'b0;
          2'd1:
            if (state == START) sda_oe <= 1'b1;
          2'd2:
            unique case (1'b1)
              is_ack:
                if (sda_in) ack_err <= 1'b1;
              state == READ:
                rdata <= {rdata[6:0], sda_in};
              state == STOP:
                sda_oe <= 1'b0;
              default: ;
            endcase
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_master.sv
// tb_i2c_master: bus-level slave model plus slot/phase model
// of the expected SCL/SDA waveform, busy and done.
module tb_i2c_master;

  localparam int D = 4;
  localparam logic [6:0] SLV_ADDR = 7'h50;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       rw = 1'b0;
  logic [6:0] addr = '0;
  logic [7:0] wdata = '0;
  logic [7:0] rdata;
  logic       busy, done, ack_err, scl;
  wire        sda;

  logic       slv_low = 1'b0;
  logic [7:0] slv_rd = '0;
  logic [7:0] got_addr = '0;
  logic [7:0] got_data = '0;
  logic [7:0] sh = '0;
  logic       in_txn = 1'b0;
  int         scl_rises = 0;
  int         base = 0;
  int         starts = 0;
  int         stops = 0;
  int         nsamp;
  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_rdata = '0;

  pullup (sda);
  assign sda   = slv_low ? 1'b0 : 1'bz;
  assign nsamp = scl_rises - base;

  i2c_master #(.CLK_DIV(D)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .rw      (rw),
    .addr    (addr),
    .wdata   (wdata),
    .rdata   (rdata),
    .busy    (busy),
    .done    (done),
    .ack_err (ack_err),
    .scl     (scl),
    .sda     (sda)
  );

  always #5 clk = ~clk;

  // Any SDA edge with SCL high is a START (fall) or STOP (rise).
  always @(posedge sda or negedge sda) begin
    if (scl) begin
      if (!sda) begin
        starts <= starts + 1;
        in_txn <= 1'b1;
        base   <= scl_rises;
      end else begin
        stops  <= stops + 1;
        in_txn <= 1'b0;
      end
    end
  end

  always @(posedge scl) begin
    scl_rises <= scl_rises + 1;
    sh <= {sh[6:0], sda};
    if (in_txn && nsamp == 7)  got_addr <= {sh[6:0], sda};
    if (in_txn && nsamp == 16) got_data <= {sh[6:0], sda};
  end

  always @(negedge scl) begin
    slv_low <= 1'b0;
    if (in_txn && got_addr[7:1] == SLV_ADDR) begin
      if (nsamp == 8)
        slv_low <= 1'b1;
      else if (got_addr[0] && nsamp >= 9 && nsamp <= 16)
        slv_low <= ~slv_rd[3'(16 - nsamp)];
      else if (!got_addr[0] && nsamp == 17)
        slv_low <= 1'b1;
    end
  end

  task automatic chk1(input string n, input logic a, input logic e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %b expected %b", n, a, e);
    end
  endtask

  task automatic chk8(input string n, input logic [7:0] a,
                      input logic [7:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  task automatic chki(input string n, input int a, input int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, a, e);
    end
  endtask

  task automatic run(input logic r, input logic [6:0] a,
                     input logic [7:0] wd, input logic [7:0] srd,
                     input bit rep, input int exp_lat,
                     input logic [7:0] exp_ab,
                     input logic [7:0] exp_wb);
    logic [7:0] ab;
    bit   resp, abort, sda_chk;
    logic sda_e, scl_e;
    int   nslots, total, s, ph, lat, st0, sp0;
    ab   = {a, r};
    resp = (a == SLV_ADDR);
`ifdef I2C_ACK_ABORT_EN
    abort = !resp;
`else
    abort = 1'b0;
`endif
    nslots = abort ? 11 : 20;
    total  = nslots * 4 * D;
    if (r && !abort) exp_rdata = resp ? srd : 8'hFF;
    lat    = -1;
    slv_rd = srd;
    @(negedge clk);
    st0 = starts;
    sp0 = stops;
    rw = r; addr = a; wdata = wd; start = 1'b1;
    for (int k = 0; k <= total; k++) begin
      @(negedge clk);
      if (k == 0) start = 1'b0;
      if (done && lat < 0) lat = k;
      s  = k / (4 * D);
      ph = (k % (4 * D)) / D;
      if (k == total) begin
        chk1($sformatf("done k=%0d", k), done, 1'b1);
        chk1($sformatf("busy k=%0d", k), busy, 1'b0);
        chk1($sformatf("scl k=%0d", k), scl, 1'b1);
        chk1($sformatf("sda k=%0d", k), sda, 1'b1);
      end else begin
        chk1($sformatf("busy k=%0d", k), busy, 1'b1);
        chk1($sformatf("done k=%0d", k), done, 1'b0);
        scl_e   = (s == 0) ? 1'b1 : (ph >= 2);
        sda_chk = 1'b1;
        sda_e   = 1'b1;
        if (s == 0)               sda_e = (ph < 2);
        else if (ph == 0)         sda_chk = 1'b0;
        else if (s == nslots - 1) sda_e = (ph == 3);
        else if (s <= 8)          sda_e = ab[3'(8 - s)];
        else if (s == 9)          sda_e = !resp;
        else if (s <= 17)
          sda_e = r ? srd[3'(17 - s)] : wd[3'(17 - s)];
        else                      sda_e = r ? 1'b1 : !resp;
        chk1($sformatf("scl k=%0d", k), scl, scl_e);
        if (sda_chk)
          chk1($sformatf("sda k=%0d", k), sda, sda_e);
      end
      if (rep && k == 50) begin
        start = 1'b1; addr = 7'h22; rw = ~r; wdata = ~wd;
      end
      if (rep && k == 51) start = 1'b0;
    end
    chki("latency", lat, exp_lat);
    chk1("ack_err", ack_err, !resp);
    chk8("rdata", rdata, exp_rdata);
    chk8("addr_byte", got_addr, exp_ab);
    if (!r && resp) chk8("slave_rx", got_data, exp_wb);
    chki("start_cond", starts - st0, 1);
    chki("stop_cond", stops - sp0, 1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk1("rst_scl", scl, 1'b1);
    chk1("rst_sda", sda, 1'b1);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_ack_err", ack_err, 1'b0);
    chk8("rst_rdata", rdata, 8'h00);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    run(1'b0, 7'h50, 8'hA5, 8'h00, 1'b0, 320, 8'hA0, 8'hA5);
    run(1'b1, 7'h50, 8'h00, 8'h3C, 1'b0, 320, 8'hA1, 8'h00);
    run(1'b0, 7'h50, 8'h5A, 8'h00, 1'b1, 320, 8'hA0, 8'h5A);
`ifdef I2C_ACK_ABORT_EN
    run(1'b0, 7'h22, 8'h0F, 8'h00, 1'b0, 176, 8'h44, 8'h00);
`else
    run(1'b0, 7'h22, 8'h0F, 8'h00, 1'b0, 320, 8'h44, 8'h00);
`endif

    @(negedge clk);
    rw = 1'b0; addr = 7'h50; wdata = 8'h11; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (40) @(negedge clk);
    chk1("pre_rst_busy", busy, 1'b1);
    rst = 1'b1;
    #1;
    chk1("arst_scl", scl, 1'b1);
    chk1("arst_sda", sda, 1'b1);
    chk1("arst_busy", busy, 1'b0);
    chk1("arst_done", done, 1'b0);
    @(negedge clk);
    chk1("arst_ack_err", ack_err, 1'b0);
    chk8("arst_rdata", rdata, 8'h00);
    rst = 1'b0;
    exp_rdata = 8'h00;
    repeat (4) @(negedge clk);
    run(1'b0, 7'h50, 8'hC3, 8'h00, 1'b0, 320, 8'hA0, 8'hC3);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
